// File: rtl/router_port_ctrl_if.sv
// rtl/router_port_ctrl_if.sv - FSM/FIFO-side signal bundle for the router output-port controller
interface router_port_ctrl_if;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    modport master (
        output detect_add, data_in, write_enb_reg,
        output read_enb_0, read_enb_1, read_enb_2,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );
endinterface

// File: rtl/router_port_ctrl.sv
// rtl/router_port_ctrl.sv - router output-port steering, full/valid routing and per-port read watchdog
module router_port_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5
) (
    input  logic                clock,
    input  logic                resetn,
    router_port_ctrl_if.slave   bus
);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [1:0]    addr_q, addr_d;
    logic [2:0]    vld, rd, stall;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    soft_reset_q, soft_reset_d;

    assign vld   = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    assign rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign stall = vld & ~rd;

    assign bus.vld_out_0    = vld[0];
    assign bus.vld_out_1    = vld[1];
    assign bus.vld_out_2    = vld[2];
    assign bus.soft_reset_0 = soft_reset_q[0];
    assign bus.soft_reset_1 = soft_reset_q[1];
    assign bus.soft_reset_2 = soft_reset_q[2];

    assign addr_d = bus.detect_add ? bus.data_in : addr_q;

    // Address 3 is a legal "no port" selection: nothing written, never full.
    always_comb begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
        case (addr_q)
            2'd0: bus.fifo_full = bus.full_0;
            2'd1: bus.fifo_full = bus.full_1;
            2'd2: bus.fifo_full = bus.full_2;
            default: bus.fifo_full = 1'b0;
        endcase
        if (bus.write_enb_reg && addr_q != 2'd3) begin
            bus.write_enb[addr_q] = 1'b1;
        end
    end

    // The pulse cycle doubles as a holdoff so pulses can never be back-to-back.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            cnt_d[n]        = '0;
            soft_reset_d[n] = 1'b0;
            if (!soft_reset_q[n] && stall[n]) begin
                if (cnt_q[n] == LAST) begin
                    soft_reset_d[n] = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q       <= 2'd3;
            soft_reset_q <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            addr_q       <= addr_d;
            soft_reset_q <= soft_reset_d;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end
endmodule

// File: doc/router_port_ctrl.md
# router_port_ctrl

Output-port control block for the 1x3 router, sitting between the router FSM and the three output FIFOs. It latches the destination port from the header byte and steers the FSM's write strobe to the selected FIFO. It also returns that FIFO's full flag to the FSM and drives per-port valid outputs. Each port has a read-timeout watchdog that issues a one-cycle soft reset when a destination leaves its packet unread too long.

## Interface

Parameters:
- TIMEOUT, 30, consecutive unread cycles before a port is soft-reset (≥2)
- CW, 5, watchdog counter width; must hold TIMEOUT-1

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  reset; synchronous, active-low
- detect_add  in  1  FSM in address-decode state; capture data_in
- data_in  in  2  header address field (0,1,2 valid; 3 = no port)
- write_enb_reg  in  1  FSM write strobe for the payload
- read_enb_0/1/2  in  1  per-port read enable from the destination
- empty_0/1/2  in  1  per-port FIFO empty flags
- full_0/1/2  in  1  per-port FIFO full flags
- write_enb  out  3  one-hot FIFO write enable; bit n = port n
- fifo_full  out  1  full flag of the currently addressed FIFO
- vld_out_0/1/2  out  1  port n holds data
- soft_reset_0/1/2  out  1  one-cycle watchdog reset to FIFO n and to the FSM

## Operation

- Address register addr[1:0]:
  - Reset value 2'b11 (no port).
  - At each clock edge where detect_add=1, addr<=data_in; otherwise it holds.
  - addr=3 is legal and selects no port.
- write_enb (combinational): if write_enb_reg=1 and addr<3, then write_enb[addr]=1 and all other bits are 0. Otherwise 3'b000.
- fifo_full (combinational): full_<addr> when addr<3, else 0.
- vld_out_n = ~empty_n (combinational).
- Per-port watchdog, three identical instances; port n uses cnt_n[CW-1:0]:
  - A stall cycle is one where vld_out_n=1 and read_enb_n=0.
  - Stall cycle with cnt_n<TIMEOUT-1: cnt_n<=cnt_n+1.
  - Stall cycle with cnt_n==TIMEOUT-1: cnt_n<=0, soft_reset_n<=1.
  - Non-stall cycle: cnt_n<=0.
  - soft_reset_n is registered and high for exactly one cycle. It is 0 in every cycle it is not set by the rule above.
  - In the cycle soft_reset_n=1, cnt_n is forced to hold 0 regardless of stall, so back-to-back pulses cannot occur.
- The three ports are fully independent. Any combination of soft resets may fire in the same cycle.
- The counter never wraps; it saturates by construction at TIMEOUT-1 before it clears.

## Timing

- resetn=0 at an edge: addr=3, every cnt_n=0, every soft_reset_n=0. Combinational outputs follow immediately: write_enb=0 and fifo_full=0. vld_out follows the empty flags.
- Reset taking effect mid-packet drops the address. Writes are blocked until the next detect_add.
- Address latency: addr updates at the edge that samples detect_add=1. A write_enb_reg asserted in that same cycle uses the old addr.
- write_enb, fifo_full and vld_out have zero latency from their inputs.
- Watchdog latency: TIMEOUT consecutive stall samples, at edges 1..TIMEOUT, make soft_reset_n go high after edge TIMEOUT. It stays high for one cycle.
- A read_enb_n=1 sample at any edge, including edge TIMEOUT, restarts the count; no pulse fires.
- The FIFO going empty (vld_out_n=0) restarts the count identically.
- The block ignores its own soft_reset outputs apart from the holdoff cycle. FIFO and FSM consume them.

## Test plan

- Reset: hold resetn=0 for 2 cycles with empty_*=1 and write_enb_reg=1. Require write_enb=000, fifo_full=0, soft_reset_*=0, vld_out_*=0.
- Steering: detect_add=1, data_in=2 for one cycle, then write_enb_reg=1 with full_2=1. Require write_enb=100 and fifo_full=1. Repeat with data_in=3 and require write_enb=000, fifo_full=0.
- Same-cycle capture: addr=1, then detect_add=1, data_in=0 and write_enb_reg=1 in one cycle. Require write_enb=010 that cycle and 001 the next.
- Timeout fire: empty_0=0, read_enb_0=0 held. Require soft_reset_0=1 only in the cycle after the 30th stall edge, then 0 for at least the next cycle. Require soft_reset_1/2 to stay 0.
- Timeout abort: same as the previous scenario but read_enb_0=1 for one cycle at stall edge 29. Require no pulse until 30 further stall edges.
- Concurrent ports: ports 1 and 2 stall from the same edge. Require soft_reset_1 and soft_reset_2 to pulse in the same cycle. Assert resetn=0 at stall edge 15 and require no pulse afterwards without a fresh 30-cycle stall.
